// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection, and the IF/ID pipeline register.
// Jumps resolve here with no bubble. The halt opcode freezes fetch until a redirect arrives.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        halted
);
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;

    logic [31:0] pc4;
    logic [5:0]  op;
    logic        is_jump;
    logic        halt_hit;

    // Low target bits are forced to zero, so they never reach the PC.
    logic unused_target_bits;
    assign unused_target_bits = &{1'b0, redirect_target[1:0]};

    assign pc4      = pc_q + 32'd4;
    assign op       = instr_data[31:26];
    assign is_jump  = (op == OP_J) || (op == OP_JAL);
    assign halt_hit = (state_q == ST_RUN) && (op == HALT_OPCODE);

    // redirect_valid has no ready: it is accepted on every edge it is high and wins over
    // stall, HALT and anything fetched that cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;

        if (redirect_valid) begin
            pc_d       = {redirect_target[31:2], 2'b00};
            state_d    = ST_RUN;
            if_valid_d = 1'b0;
        end else if (state_q == ST_HALT) begin
            if_valid_d = 1'b0;
        end else if (stall) begin
            if_valid_d = if_valid_q;
        end else if (halt_hit) begin
            // The halt word is dropped and the PC stays on it.
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
        end else begin
            pc_d       = is_jump ? {pc4[31:28], instr_data[25:0], 2'b00} : pc4;
            if_valid_d = 1'b1;
            if_instr_d = instr_data;
            if_pc_d    = pc_q;
            if_pc4_d   = pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    assign instr_addr  = pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc4_q;
    assign halted      = (state_q == ST_HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction ROM and hand-computed expectations.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        halted;

    logic        alt_prog;
    int          checks_n;
    int          errors_n;
    logic [31:0] exp_q[$];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_addr      (instr_addr),
        .instr_data      (instr_data),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .halted          (halted)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // alt_prog swaps the jump at 32 for a plain ALU op so fetch can walk into the halt word.
    function automatic logic [31:0] imem(input logic [31:0] a, input logic alt);
        case (a)
            32'd0:   imem = 32'h2108_0002;
            32'd4:   imem = 32'h214A_0002;
            32'd8:   imem = 32'h010A_4020;
            32'd12:  imem = 32'h012A_5820;
            32'd16:  imem = 32'hAD09_0000;
            32'd20:  imem = 32'h8D0B_0000;
            32'd24:  imem = 32'h0109_4022;
            32'd28:  imem = 32'h1109_0048;
            32'd32:  imem = alt ? 32'h0000_0020 : 32'h0800_0007;
            32'd36:  imem = 32'hFCFF_FFFF;
            default: imem = 32'h0000_0000;
        endcase
    endfunction

    always_comb instr_data = imem(instr_addr, alt_prog);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks: each step advances one edge and leaves #1 to sample outputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"}, instr_addr, 32'd0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_instr"}, if_instr, 32'd0);
        check({tag, "_pc"}, if_pc, 32'd0);
        check({tag, "_pc4"}, if_pc_plus4, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    task automatic check_fetched(input string tag, input logic [31:0] addr,
                                 input logic [31:0] prev);
        check({tag, "_addr"}, instr_addr, addr);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, "_pc"}, if_pc, prev);
        check({tag, "_pc4"}, if_pc_plus4, prev + 32'd4);
        check({tag, "_instr"}, if_instr, imem(prev, alt_prog));
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        step();
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] exp_addr;
        checks_n        = 0;
        errors_n        = 0;
        alt_prog        = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;

        // Program run with the j-loop at 28/32
        do_reset();
        check_reset_state("rst");
        foreach (exp_q[i]) exp_q.delete(i);
        for (int a = 4; a <= 32; a += 4) exp_q.push_back(a);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'd28);
            exp_q.push_back(32'd32);
        end
        prev = 32'd0;
        while (exp_q.size() > 0) begin
            exp_addr = exp_q.pop_front();
            step();
            check_fetched("run", exp_addr, prev);
            prev = exp_addr;
        end

        // Stall for 3 cycles at PC=8
        do_reset();
        step();
        step();
        check_fetched("pre_stall", 32'd8, 32'd4);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr", instr_addr, 32'd8);
            check("stall_instr", if_instr, 32'h214A_0002);
            check("stall_pc", if_pc, 32'd4);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check_fetched("resume", 32'd12, 32'd8);

        // Redirect beats a simultaneous stall; low target bits ignored
        stall = 1'b1;
        redirect_to(32'h0000_0013);
        stall = 1'b0;
        check("redir_addr", instr_addr, 32'h10);
        check("redir_squash", {31'd0, if_valid}, 32'd0);
        step();
        check_fetched("redir_tgt", 32'h14, 32'h10);
        check("redir_instr", if_instr, 32'hAD09_0000);

        // Sequential walk 24..36 into the halt word
        alt_prog = 1'b1;
        redirect_to(32'd24);
        check("walk_addr", instr_addr, 32'd24);
        step();
        check_fetched("walk28", 32'd28, 32'd24);
        step();
        check_fetched("walk32", 32'd32, 32'd28);
        step();
        check_fetched("walk36", 32'd36, 32'd32);
        check("pre_halt", {31'd0, halted}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_addr", instr_addr, 32'd36);
            check("halt_valid", {31'd0, if_valid}, 32'd0);
        end

        // Redirect out of HALT
        redirect_to(32'h18);
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        check("unhalt_addr", instr_addr, 32'h18);
        check("unhalt_valid", {31'd0, if_valid}, 32'd0);
        step();
        check_fetched("unhalt_run", 32'h1C, 32'h18);
        check("unhalt_instr", if_instr, 32'h0109_4022);

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFFC);
        check("wrap_pre", instr_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", instr_addr, 32'd0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_pc_plus4, 32'd0);
        check("wrap_valid", {31'd0, if_valid}, 32'd1);

        // Reset mid-stall
        step();
        step();
        stall = 1'b1;
        rst_n = 1'b0;
        step();
        check_reset_state("rst_stall");
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        check_fetched("after_rst", 32'd4, 32'd0);

        // Reset while halted
        redirect_to(32'd36);
        step();
        check("halt2_flag", {31'd0, halted}, 32'd1);
        rst_n = 1'b0;
        step();
        check_reset_state("rst_halt");
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the instruction memory's `address` input and captures its `instruction` output into the IF/ID pipeline register. It holds the program counter and selects the next PC from four sources: sequential, in-stage jump, downstream redirect and hold. It resolves `j`/`jal` in the fetch stage with no bubble. It also detects the halt word (opcode 6'h3F) and freezes fetch.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `HALT_OPCODE`, 6'h3F: opcode bits [31:26] that stop fetch.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hazard unit request to hold the PC and IF/ID contents.
- `redirect_valid`  in  1  taken branch, or other PC override, from downstream.
- `redirect_target`  in  32  byte address for the redirect; bits [1:0] are ignored and treated as 0.
- `instr_addr`  out  32  byte address to the instruction memory; always equals the PC register.
- `instr_data`  in  32  instruction memory output, combinational from `instr_addr`.
- `if_valid`  out  1  IF/ID contents are a real instruction.
- `if_instr`  out  32  IF/ID instruction.
- `if_pc`  out  32  IF/ID address of `if_instr`.
- `if_pc_plus4`  out  32  IF/ID value of `if_pc` + 4, used for link and branch base.
- `halted`  out  1  fetch is stopped in the HALT state.

## Operation

- States: RUN and HALT. Reset enters RUN.
- Reset (`rst_n`=0 at an edge) sets:
  - PC = RESET_PC;
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0;
  - `halted`=0.
- Reset has priority over every other input.
- Definitions used below:
  - `pc4` = PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - `op` = `instr_data`[31:26].
  - jump = `op` is 6'h02 or 6'h03.
  - halt_hit = `op` == HALT_OPCODE, in RUN.
- Next-PC priority, evaluated each edge (first match wins):
  1. `redirect_valid`: PC = {`redirect_target`[31:2], 2'b00}. State becomes RUN, including when leaving HALT.
  2. HALT state: PC holds.
  3. `stall`: PC holds.
  4. halt_hit: PC holds and state becomes HALT.
  5. jump: PC = {`pc4`[31:28], `instr_data`[25:0], 2'b00}.
  6. Otherwise: PC = `pc4`.
- IF/ID register update, same priority:
  - `redirect_valid`: `if_valid`=0, which squashes the wrong-path instruction. Other fields are don't-care and keep their old values.
  - HALT state: `if_valid`=0.
  - `stall`: all IF/ID fields hold, `if_valid` included.
  - halt_hit: `if_valid`=0. The halt word is never forwarded downstream.
  - Otherwise, jumps included: `if_valid`=1, `if_instr`=`instr_data`, `if_pc`=PC, `if_pc_plus4`=`pc4`.
- `halted` = 1 exactly while in the HALT state.
- A redirect takes precedence over a simultaneous `stall`. Downstream guarantees the redirect corresponds to an older instruction.
- No reads of `instr_data` occur in HALT. The unit ignores its value there.

## Timing

- Fetch latency: the instruction at PC is sampled at the same edge PC advances, because memory reads are combinational. One instruction per cycle when not stalled.
- Jump penalty: 0 cycles. The target address appears on `instr_addr` one cycle after the jump is presented.
- Redirect penalty: the IF/ID slot that is valid in the redirect cycle is owned by downstream. The unit squashes the instruction fetched that cycle. `instr_addr` = target in the next cycle, and `if_valid`=1 for the target one cycle after that.
- HALT entry: `halted`=1 in the cycle after halt_hit, with `instr_addr` still pointing at the halt word.
- `stall` held for N cycles holds PC and IF/ID for N cycles. Resume is on the first edge with `stall`=0.
- Reset asserted mid-operation, including in HALT or mid-stall: next cycle reflects reset values. No partial state survives.

## Test plan

- Reset then run the program 0:21080002, 4:214A0002, 8:010A4020, ..., 24:01094022, 28:11090048, 32:08000007, 36:FCFFFFFF, with no stall or redirect.
  - Required: `instr_addr` sequence 0,4,8,12,16,20,24,28,32,28,32,...; `if_valid`=1 each cycle after the first.
  - Required: `if_pc_plus4`=`if_pc`+4.
- Sequential walk from 24: 24,28,32,36. At 36 (FCFFFFFF) the required response is `halted`=1 next cycle, `instr_addr` stays 36, and `if_valid`=0 thereafter.
- Assert `stall` for 3 cycles while PC=8.
  - Required: `instr_addr`=8 and IF/ID hold `if_instr`=214A0002, `if_pc`=4 for 3 cycles.
  - Required: fetch then resumes at 12.
- `redirect_valid`=1 with target 32'h0000_0013 while `stall`=1.
  - Required: next `instr_addr`=0x10, `if_valid`=0 for one cycle, then `if_instr`=AD090000.
- In HALT, pulse `redirect_valid` with target 0x18.
  - Required: `halted`=0 next cycle, `instr_addr`=0x18, and normal fetch resumes.
- With PC=32'hFFFF_FFFC and a non-jump instruction: next `instr_addr`=0.
- Assert `rst_n`=0 mid-run: required PC=RESET_PC, all IF/ID outputs 0, `halted`=0 on the next cycle.
